// File: rtl/conv2_viterbi_dec.sv
// conv2_viterbi_dec: hard-decision Viterbi decoder for the 4-state rate-1/2
// conv2 code. One ACS unit per trellis state, register-exchange survivors,
// so every decision leaves exactly TB_DEPTH symbols after its own symbol.

// One add-compare-select cell: two candidate branches into one state.
module conv2_viterbi_acs #(
   parameter int PM_W     = 6,
   parameter int TB_DEPTH = 16
) (
   input  logic [PM_W-1:0]     pm_a,
   input  logic [PM_W-1:0]     pm_b,
   input  logic [1:0]          bm_a,
   input  logic [1:0]          bm_b,
   input  logic [TB_DEPTH-1:0] surv_a,
   input  logic [TB_DEPTH-1:0] surv_b,
   input  logic                x_a,
   input  logic                x_b,
   output logic [PM_W-1:0]     pm_new,
   output logic [TB_DEPTH-1:0] surv_new
);
   localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

   logic [PM_W:0]   sum_a, sum_b;
   logic [PM_W-1:0] cand_a, cand_b;

   // saturating add, then keep the smaller; branch a (lower predecessor) wins ties
   always_comb begin
      sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
      sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
      cand_a = (sum_a > PM_MAX) ? PM_MAX[PM_W-1:0] : sum_a[PM_W-1:0];
      cand_b = (sum_b > PM_MAX) ? PM_MAX[PM_W-1:0] : sum_b[PM_W-1:0];
      if (cand_a <= cand_b) begin
         pm_new   = cand_a;
         surv_new = {surv_a[TB_DEPTH-2:0], x_a};
      end else begin
         pm_new   = cand_b;
         surv_new = {surv_b[TB_DEPTH-2:0], x_b};
      end
   end
endmodule

module conv2_viterbi_dec #(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_valid,
   input  logic [1:0] sym_in,
   input  logic       flush,
   output logic       bit_valid,
   output logic       bit_out,
   output logic       busy
);
   localparam int              CW       = $clog2(TB_DEPTH + 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(TB_DEPTH);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [PM_W-1:0] HALF     = {1'b1, {(PM_W-1){1'b0}}};
   localparam logic [PM_W-1:0] PM_INIT  = {1'b0, {(PM_W-1){1'b1}}};

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;
   state_t state, state_nxt;

   logic [3:0][PM_W-1:0]     pm, pm_acs, pm_nxt;
   logic [3:0][TB_DEPTH-1:0] surv, surv_acs;
   logic [CW-1:0]            pending, fl_rem;
   logic [TB_DEPTH-1:0]      fl_sr, fl_sh;
   logic [1:0]               best;
   logic [PM_W-1:0]          best_pm;
   logic                     accept, fl_start, fl_done, norm;

   assign accept   = sym_valid && (state == ST_RUN);
   assign fl_start = flush && !sym_valid && (state == ST_RUN);
   assign fl_done  = (state == ST_FLUSH) && (fl_rem == '0);

   // Per-state ACS. Predecessors of s0/s1 are s0,s2; of s2/s3 are s1,s3.
   // An even predecessor emits {x,x}, an odd one emits {x,~x}.
   for (genvar s = 0; s < 4; s++) begin : g_acs
      localparam int         PA = (s < 2) ? 0 : 1;
      localparam int         PB = PA + 2;
      localparam logic       XA = (s == 1 || s == 2);
      localparam logic       XB = !XA;
      localparam logic [1:0] EA = (PA == 1) ? {XA, !XA} : {XA, XA};
      localparam logic [1:0] EB = (PB == 3) ? {XB, !XB} : {XB, XB};

      logic [1:0] d_a, d_b, bm_a, bm_b;
      assign d_a  = sym_in ^ EA;
      assign d_b  = sym_in ^ EB;
      assign bm_a = {d_a[1] & d_a[0], d_a[1] ^ d_a[0]};
      assign bm_b = {d_b[1] & d_b[0], d_b[1] ^ d_b[0]};

      conv2_viterbi_acs #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) u_acs (
         .pm_a     (pm[PA]),
         .pm_b     (pm[PB]),
         .bm_a     (bm_a),
         .bm_b     (bm_b),
         .surv_a   (surv[PA]),
         .surv_b   (surv[PB]),
         .x_a      (XA),
         .x_b      (XB),
         .pm_new   (pm_acs[s]),
         .surv_new (surv_acs[s])
      );
   end

   // pull all metrics down by half once every one of them has reached it
   always_comb begin
      norm = 1'b1;
      for (int i = 0; i < 4; i++)
         if (pm_acs[i] < HALF) norm = 1'b0;
      for (int i = 0; i < 4; i++)
         pm_nxt[i] = norm ? (pm_acs[i] - HALF) : pm_acs[i];
   end

   // best state on the current metrics, lowest index on ties
   always_comb begin
      best    = 2'd0;
      best_pm = pm[0];
      for (int i = 1; i < 4; i++)
         if (pm[i] < best_pm) begin
            best    = 2'(i);
            best_pm = pm[i];
         end
   end

   // best survivor aligned so its oldest pending bit sits at the MSB
   always_comb begin
      fl_sh = surv[best] << (CNT_FULL - pending);
   end

   // flush state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // flush next-state: enter on an accepted flush, leave once drained
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (fl_start) state_nxt = ST_FLUSH;
         ST_FLUSH: if (fl_rem == '0) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // flush outputs
   always_comb begin
      busy = (state == ST_FLUSH);
   end

   // metrics, survivors and pending count; block end restores start values
   always_ff @(posedge clk) begin
      if (rst || fl_done) begin
         pm      <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
         surv    <= '0;
         pending <= '0;
      end else if (accept) begin
         pm   <= pm_nxt;
         surv <= surv_acs;
         if (pending != CNT_FULL) pending <= pending + CNT_ONE;
      end
   end

   // decided-bit output: streaming decisions, then the flush drain
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         fl_sr     <= '0;
         fl_rem    <= '0;
      end else if (accept) begin
         bit_valid <= (pending == CNT_FULL);
         bit_out   <= (pending == CNT_FULL) & surv[best][TB_DEPTH-1];
      end else if (fl_start) begin
         bit_valid <= (pending != '0);
         bit_out   <= fl_sh[TB_DEPTH-1];
         fl_sr     <= fl_sh << 1;
         fl_rem    <= (pending != '0) ? (pending - CNT_ONE) : '0;
      end else if (busy && fl_rem != '0) begin
         bit_valid <= 1'b1;
         bit_out   <= fl_sr[TB_DEPTH-1];
         fl_sr     <= fl_sr << 1;
         fl_rem    <= fl_rem - CNT_ONE;
      end else begin
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
      end
   end
endmodule

// File: doc/conv2_viterbi_dec.md
Name: conv2_viterbi_dec

Overview:
- Hard-decision Viterbi decoder for the 4-state rate-1/2 code produced by conv2, the constituent encoder of the turbo encoder.
- Accepts one received symbol pair per valid cycle and outputs the recovered information bits in order.
- Uses add-compare-select (ACS) with register-exchange survivor storage, so decode latency is fixed.
- Sits at the receive end of the turbo link and is the reference decoder for bit-true loopback against conv2.

Parameters:
- TB_DEPTH, 16: survivor length in symbols, i.e. decode delay; legal range 4..64.
- PM_W, 6: path-metric width in bits; must be at least 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sym_valid  in  1  sym_in holds a received symbol this cycle.
- sym_in  in  2  received pair: [1] is the first serial bit (enc_out[1]), [0] the second.
- flush  in  1  one-cycle pulse marking end of block: drain all pending bits.
- bit_valid  out  1  bit_out is valid this cycle.
- bit_out  out  1  decoded information bit.
- busy  out  1  high while flushing; sym_valid and flush are ignored while busy.

Behaviour:
- Trellis, written as state, input x -> next state / output pair:
  - s0: x=0 -> s0/00; x=1 -> s1/11.
  - s1: x=0 -> s3/01; x=1 -> s2/10.
  - s2: x=0 -> s1/00; x=1 -> s0/11.
  - s3: x=0 -> s2/01; x=1 -> s3/10.
- Predecessors of each next state:
  - s0 from s0 (x=0) or s2 (x=1).
  - s1 from s0 (x=1) or s2 (x=0).
  - s2 from s1 (x=1) or s3 (x=0).
  - s3 from s1 (x=0) or s3 (x=1).
- Branch metric: Hamming distance (0..2) between sym_in and the expected pair.
- ACS: candidate = predecessor metric + branch metric, keeping the smaller. On a tie, take the lower-indexed predecessor.
- Survivors: each new survivor is the winning predecessor's survivor shifted left by one, with that branch's x appended as the LSB.
- Metric normalization: when all four new metrics are >= 2^(PM_W-1), subtract 2^(PM_W-1) from all four in the same cycle. Metrics saturate at 2^PM_W - 1 and never wrap.
- Reset, and start of each block:
  - Metrics: s0 = 0; s1, s2, s3 = 2^(PM_W-1) - 1. This biases the decoder toward conv2's s0 start.
  - Survivors all 0; pending count 0.
  - bit_valid = 0, bit_out = 0, busy = 0.
- Normal operation, per accepted symbol:
  - The ACS update completes in the same cycle, and pending increments, saturating at TB_DEPTH.
  - If pending was already TB_DEPTH before this symbol, then on the next cycle bit_valid = 1 and bit_out = bit TB_DEPTH-1 of the best state's survivor, taken before the shift.
  - Best state is the minimum metric; ties resolve to the lowest index.
  - Result: the bit for symbol k appears one cycle after symbol k+TB_DEPTH is accepted.
- Gaps in sym_valid hold all state unchanged; no output is produced during a gap.
- Flush:
  - Accepted only when not busy and sym_valid = 0. If flush and sym_valid are high together, the symbol is accepted and the flush is ignored.
  - Next cycle busy = 1. The best state is latched once, and its survivor emits the remaining pending bits, oldest first, one per cycle with bit_valid = 1.
  - After the last bit, busy = 0 and metrics/survivors/pending return to their reset values.
  - Flush with pending = 0 gives busy for one cycle and no output bits.
- rst mid-block or mid-flush: everything returns to reset values on the next edge, with no partial output afterward.
- bit_valid is never high for two different decisions in the same cycle. The output rate is at most one bit per cycle.

Test Plan:
- rst, then 40 symbols of 00, then flush -> 40 zero bits total: 24 during streaming and 16 during flush. busy is high for 16 cycles.
- Info bits 1,0,1,1,0 sent as symbols 11,01,10,10,01, then flush -> decoded 1,0,1,1,0 exactly, with the first bit only after flush (pending 5 < TB_DEPTH).
- 200 random bits encoded by a conv2 model, with a single symbol-bit flip every 20 symbols -> all 200 bits match. First bit_valid arrives one cycle after symbol index 16 is accepted.
- Same stream with random 0-3 cycle gaps in sym_valid -> identical bit sequence, and no bit_valid during gaps.
- Long all-error stream (each symbol complemented, 300 symbols) -> metrics never wrap, normalization fires, and the output stays deterministic and matches a golden model.
- rst asserted mid-flush with 8 bits left -> bit_valid drops the next cycle, busy = 0, and a fresh block then decodes correctly from s0.
